ddr_arbiter: RTL and testbench

Two-requester arbiter that shares the single DDR line-transfer port (256-bit line, 4-byte-aligned 30-bit address) between the instruction-side and data-side caches.
- Sits between the cache refill/writeback engines and the DDR controller, in the ui_clk domain.
- Grants round-robin, latches the winning request, drives one downstream transaction, returns read data and a one-cycle done pulse.
- Keeps a sticky timeout flag for stalled transactions.

---
 rtl/ddr_pkg.sv | 19 +
 rtl/rr_arb2.sv | 33 +++
 rtl/ddr_arbiter.sv | 144 ++++++++++++++
 tb/tb_ddr_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR line-port arbiter.
package ddr_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 30;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // One-hot grant vector for a two-requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; pointer moves past the last owner on advance.
module rr_arb2 #(
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic       ui_clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic       valid,
  output logic       winner
);

  localparam logic PRIO_INIT = (PRIO_RESET != 0);

  logic ptr_q;

  // Pointer register: favour the requester that did not just finish.
  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      ptr_q <= PRIO_INIT;
    end else if (advance) begin
      ptr_q <= ~owner;
    end
  end

  // Pointer only matters when both are asking.
  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ptr_q : req[1];
  end

endmodule

// File: rtl/ddr_arbiter.sv
// Round-robin arbiter sharing one DDR line port between I-side and D-side caches.
module ddr_arbiter
  import ddr_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned PRIO_RESET     = 0
) (
  input  logic                      ui_clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_en,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*LINE_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_rdy,
  output logic [LINE_W-1:0]         req_rdata,
  output logic                      mem_en,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LINE_W-1:0]         mem_wdata,
  input  logic                      mem_rdy,
  input  logic [LINE_W-1:0]         mem_rdata,
  output logic [N_REQ-1:0]          grant,
  output logic                      err_timeout
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          rdy_q, rdy_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                en_q, en_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;

  logic arb_valid, arb_winner, advance;

  rr_arb2 #(
    .PRIO_RESET (PRIO_RESET)
  ) u_rr (
    .ui_clk  (ui_clk),
    .rst     (rst),
    .req     (req_en),
    .advance (advance),
    .owner   (owner_q),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  // Next-state: grant/latch in IDLE, hold mem_* through ISSUE/WAIT, pulse rdy in DONE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    rdy_d   = 2'b00;
    rdata_d = rdata_q;
    en_d    = en_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    advance = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (arb_valid) begin
          owner_d = arb_winner;
          grant_d = onehot2(arb_winner);
          en_d    = 1'b1;
          write_d = req_write[arb_winner];
          addr_d  = arb_winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          wdata_d = arb_winner ? req_wdata[2*LINE_W-1:LINE_W] : req_wdata[LINE_W-1:0];
          state_d = ARB_ISSUE;
        end
      end
      // Controller decodes the new address this cycle, so mem_rdy is not trusted yet.
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (mem_rdy) begin
          if (!write_q) rdata_d = mem_rdata;
          en_d    = 1'b0;
          grant_d = 2'b00;
          rdy_d   = onehot2(owner_q);
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        advance = 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    // Busy-cycle counter saturates; the flag is sticky and never aborts the transfer.
    if ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT)) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (cnt_d == TIMEOUT_VAL) err_d = 1'b1;
    end
  end

  // State and output registers; reset abandons any transaction without a rdy.
  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      grant_q <= 2'b00;
      rdy_q   <= 2'b00;
      rdata_q <= '0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req_rdy     = rdy_q;
  assign req_rdata   = rdata_q;
  assign mem_en      = en_q;
  assign mem_write   = write_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign grant       = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter; inputs driven and outputs sampled on negedge.
module tb_ddr_arbiter;

  logic           ui_clk = 1'b0;
  logic           rst;
  logic [1:0]     req_en;
  logic [1:0]     req_write;
  logic [59:0]    req_addr;
  logic [511:0]   req_wdata;
  logic [1:0]     req_rdy;
  logic [255:0]   req_rdata;
  logic           mem_en;
  logic           mem_write;
  logic [29:0]    mem_addr;
  logic [255:0]   mem_wdata;
  logic           mem_rdy;
  logic [255:0]   mem_rdata;
  logic [1:0]     grant;
  logic           err_timeout;

  int checks = 0;
  int failures = 0;

  ddr_arbiter #(
    .N_REQ          (2),
    .TIMEOUT_CYCLES (16),
    .PRIO_RESET     (0)
  ) dut (
    .ui_clk      (ui_clk),
    .rst         (rst),
    .req_en      (req_en),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rdy     (req_rdy),
    .req_rdata   (req_rdata),
    .mem_en      (mem_en),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdy     (mem_rdy),
    .mem_rdata   (mem_rdata),
    .grant       (grant),
    .err_timeout (err_timeout)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic do_reset();
    rst = 1'b0;
    req_en = 2'b00;
    mem_rdy = 1'b0;
    @(negedge ui_clk);
    @(negedge ui_clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_en, mem_write} !== 2'b00) begin
      failures++; $display("FAIL reset_mem_ctl got=%b exp=00", {mem_en, mem_write});
    end
    checks++;
    if (mem_addr !== 30'h0 || mem_wdata !== 256'h0) begin
      failures++; $display("FAIL reset_mem_data got addr=%h wdata=%h exp=0", mem_addr, mem_wdata);
    end
    checks++;
    if ({req_rdy, grant, err_timeout} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {req_rdy, grant, err_timeout});
    end
    checks++;
    if (req_rdata !== 256'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", req_rdata);
    end
  endtask

  task automatic test_single_read();
    int en_cycles = 0;
    logic seen = 1'b0;
    logic [29:0] addr_first = '0;
    logic wr_first = 1'b1;
    mem_rdata = {32{8'hA5}};
    mem_rdy = 1'b0;
    req_write = 2'b00;
    req_addr = {30'h0, 30'h100};
    req_en = 2'b01;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge ui_clk);
      if (mem_en) begin
        en_cycles++;
        if (en_cycles == 1) begin
          addr_first = mem_addr;
          wr_first = mem_write;
        end
        mem_rdy = (en_cycles >= 6);
      end
      if (req_rdy != 2'b00) begin
        seen = 1'b1;
        checks++;
        if (req_rdy !== 2'b01) begin
          failures++; $display("FAIL read_rdy got=%b exp=01", req_rdy);
        end
        checks++;
        if (req_rdata !== {32{8'hA5}}) begin
          failures++; $display("FAIL read_rdata got=%h exp=a5..a5", req_rdata);
        end
        req_en = 2'b00;
        mem_rdy = 1'b0;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL read_timeout got=no_rdy exp=rdy");
    end
    checks++;
    if (en_cycles != 6) begin
      failures++; $display("FAIL read_en_cycles got=%0d exp=6", en_cycles);
    end
    checks++;
    if (addr_first !== 30'h100 || wr_first !== 1'b0) begin
      failures++; $display("FAIL read_addr got=%h/%b exp=100/0", addr_first, wr_first);
    end
    @(negedge ui_clk);
    checks++;
    if (req_rdy !== 2'b00) begin
      failures++; $display("FAIL read_rdy_pulse got=%b exp=00", req_rdy);
    end
  endtask

  task automatic test_both();
    logic [1:0] g [2];
    logic w [2];
    logic [29:0] a [2];
    logic [255:0] wd0 = '0;
    logic [255:0] rd1 = '0;
    logic [1:0] prev = 2'b00;
    int ng = 0;
    int done_cnt = 0;
    g[0] = 2'b00; g[1] = 2'b00; w[0] = 1'bx; w[1] = 1'bx; a[0] = '0; a[1] = '0;
    do_reset();
    mem_rdy = 1'b1;
    mem_rdata = {8{32'h1234_5678}};
    req_write = 2'b01;
    req_addr = {30'h300, 30'h200};
    req_wdata = {{8{32'h0}}, {8{32'hDEAD_BEEF}}};
    req_en = 2'b11;
    for (int i = 0; i < 60 && done_cnt < 2; i++) begin
      @(negedge ui_clk);
      if (grant != 2'b00 && prev == 2'b00 && ng < 2) begin
        g[ng] = grant;
        w[ng] = mem_write;
        a[ng] = mem_addr;
        if (ng == 0) wd0 = mem_wdata;
        ng++;
      end
      prev = grant;
      if (req_rdy != 2'b00) begin
        if (req_rdy == 2'b10) rd1 = req_rdata;
        req_en = req_en & ~req_rdy;
        done_cnt++;
      end
    end
    checks++;
    if (done_cnt != 2) begin
      failures++; $display("FAIL both_done got=%0d exp=2", done_cnt);
    end
    checks++;
    if (g[0] !== 2'b01 || g[1] !== 2'b10) begin
      failures++; $display("FAIL both_order got=%b,%b exp=01,10", g[0], g[1]);
    end
    checks++;
    if (w[0] !== 1'b1 || w[1] !== 1'b0) begin
      failures++; $display("FAIL both_write got=%b,%b exp=1,0", w[0], w[1]);
    end
    checks++;
    if (a[0] !== 30'h200 || a[1] !== 30'h300) begin
      failures++; $display("FAIL both_addr got=%h,%h exp=200,300", a[0], a[1]);
    end
    checks++;
    if (wd0 !== {8{32'hDEAD_BEEF}}) begin
      failures++; $display("FAIL both_wdata got=%h exp=deadbeef..", wd0);
    end
    checks++;
    if (rd1 !== {8{32'h1234_5678}}) begin
      failures++; $display("FAIL both_rdata got=%h exp=12345678..", rd1);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] g [4];
    logic [1:0] exp_g [4];
    logic [1:0] prev = 2'b00;
    logic want = 1'b1;
    int ng = 0;
    int done_cnt = 0;
    for (int k = 0; k < 4; k++) g[k] = 2'b00;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    mem_rdy = 1'b1;
    req_write = 2'b00;
    req_en = 2'b11;
    for (int i = 0; i < 80 && done_cnt < 4; i++) begin
      @(negedge ui_clk);
      if (grant != 2'b00 && prev == 2'b00 && ng < 4) begin
        g[ng] = grant;
        ng++;
        if (ng == 4) want = 1'b0;
      end
      prev = grant;
      if (req_rdy != 2'b00) done_cnt++;
      req_en = want ? ~req_rdy : 2'b00;
    end
    checks++;
    if (done_cnt != 4) begin
      failures++; $display("FAIL alt_done got=%0d exp=4", done_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (g[k] !== exp_g[k]) begin
        failures++; $display("FAIL alt_grant%0d got=%b exp=%b", k, g[k], exp_g[k]);
      end
    end
    @(negedge ui_clk);
    @(negedge ui_clk);
    checks++;
    if (grant !== 2'b00 || mem_en !== 1'b0) begin
      failures++; $display("FAIL alt_idle got=%b/%b exp=00/0", grant, mem_en);
    end
  endtask

  task automatic test_hit();
    int n = 0;
    int en_cycles = 0;
    int lat = 0;
    logic seen = 1'b0;
    logic [1:0] rv = 2'b00;
    mem_rdy = 1'b1;
    req_write = 2'b00;
    req_addr = {30'h300, 30'h0};
    req_en = 2'b10;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ui_clk);
      n++;
      if (mem_en) en_cycles++;
      if (req_rdy != 2'b00) begin
        seen = 1'b1;
        rv = req_rdy;
        lat = n;
        req_en = 2'b00;
      end
    end
    checks++;
    if (seen !== 1'b1 || rv !== 2'b10) begin
      failures++; $display("FAIL hit_rdy got=%b exp=10", rv);
    end
    checks++;
    if (lat != 3) begin
      failures++; $display("FAIL hit_latency got=%0d exp=3", lat);
    end
    checks++;
    if (en_cycles != 2) begin
      failures++; $display("FAIL hit_en_cycles got=%0d exp=2", en_cycles);
    end
    @(negedge ui_clk);
  endtask

  task automatic test_timeout();
    int n = 0;
    logic started = 1'b0;
    logic seen = 1'b0;
    logic [1:0] rv = 2'b00;
    do_reset();
    mem_rdy = 1'b0;
    req_write = 2'b00;
    req_addr = {30'h0, 30'h40};
    req_en = 2'b01;
    for (int i = 0; i < 10 && !started; i++) begin
      @(negedge ui_clk);
      if (mem_en) started = 1'b1;
    end
    checks++;
    if (started !== 1'b1) begin
      failures++; $display("FAIL to_start got=no_mem_en exp=mem_en");
    end
    while (!err_timeout && n < 40) begin
      @(negedge ui_clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++; $display("FAIL to_cycles got=%0d exp=16", n);
    end
    checks++;
    if (mem_en !== 1'b1 || grant !== 2'b01) begin
      failures++; $display("FAIL to_held got=%b/%b exp=1/01", mem_en, grant);
    end
    mem_rdy = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge ui_clk);
      if (req_rdy != 2'b00) begin
        seen = 1'b1;
        rv = req_rdy;
        req_en = 2'b00;
      end
    end
    checks++;
    if (rv !== 2'b01) begin
      failures++; $display("FAIL to_complete got=%b exp=01", rv);
    end
    @(negedge ui_clk);
    @(negedge ui_clk);
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++; $display("FAIL to_sticky got=%b exp=1", err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    logic [1:0] any_rdy = 2'b00;
    logic [1:0] first_g = 2'b00;
    logic [1:0] rv = 2'b00;
    do_reset();
    mem_rdy = 1'b1;
    mem_rdata = {32{8'h5A}};
    req_write = 2'b00;
    req_addr = {30'h300, 30'h80};
    req_wdata = {{8{32'hCAFE_F00D}}, {8{32'h0}}};
    req_en = 2'b01;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge ui_clk);
      if (req_rdy != 2'b00) begin
        seen = 1'b1;
        req_en = 2'b00;
      end
    end
    @(negedge ui_clk);
    checks++;
    if (req_rdata !== {32{8'h5A}}) begin
      failures++; $display("FAIL rm_pre_rdata got=%h exp=5a..5a", req_rdata);
    end
    mem_rdy = 1'b0;
    req_en = 2'b10;
    @(negedge ui_clk);
    @(negedge ui_clk);
    @(negedge ui_clk);
    checks++;
    if (mem_en !== 1'b1 || grant !== 2'b10) begin
      failures++; $display("FAIL rm_in_wait got=%b/%b exp=1/10", mem_en, grant);
    end
    rst = 1'b0;
    req_en = 2'b00;
    @(negedge ui_clk);
    rst = 1'b1;
    checks++;
    if ({mem_en, mem_write, req_rdy, grant, err_timeout} !== 7'b0 ||
        mem_addr !== 30'h0 || mem_wdata !== 256'h0 || req_rdata !== 256'h0) begin
      failures++;
      $display("FAIL rm_outputs got en=%b addr=%h rdy=%b grant=%b rdata=%h exp=all_zero",
               mem_en, mem_addr, req_rdy, grant, req_rdata);
    end
    mem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ui_clk);
      any_rdy = any_rdy | req_rdy;
    end
    checks++;
    if (any_rdy !== 2'b00) begin
      failures++; $display("FAIL rm_no_rdy got=%b exp=00", any_rdy);
    end
    req_en = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge ui_clk);
      if (grant != 2'b00 && first_g == 2'b00) first_g = grant;
      if (req_rdy != 2'b00) begin
        seen = 1'b1;
        rv = req_rdy;
        req_en = 2'b00;
      end
    end
    checks++;
    if (first_g !== 2'b01) begin
      failures++; $display("FAIL rm_prio got=%b exp=01", first_g);
    end
    checks++;
    if (rv !== 2'b01) begin
      failures++; $display("FAIL rm_served got=%b exp=01", rv);
    end
    @(negedge ui_clk);
    @(negedge ui_clk);
  endtask

  initial begin
    rst = 1'b0;
    req_en = 2'b00;
    req_write = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    mem_rdy = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_single_read();
    test_both();
    test_alternate();
    test_hit();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
